// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between REQUESTERS byte sources. A round-robin
//   arbiter grants the transmitter to one requester for a whole packet (ended
//   by req_last_i); the grant is also dropped if the owner stalls between
//   bytes for TIMEOUT_TICKS baud ticks.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   baud_i                one-cycle sample tick (16 per bit)
//   req_valid_i/ready_o   per-requester handshake, transfer when both high
//   req_data_i            requester i byte at [i*WORD_BITS +: WORD_BITS]
//   req_last_i            requester i byte ends its packet
//   tx_start_o/tx_data_o  start pulse and registered byte to the transmitter
//   tx_done_i             transmitter finished the stop bit
//   grant_o               one-hot current owner, 0 when free
//   busy_o                not idle
//   timeout_o             one-cycle pulse when a grant is revoked by timeout
module uart_tx_arbiter #(
    parameter int WORD_BITS     = 8,
    parameter int REQUESTERS    = 4,
    parameter int TIMEOUT_TICKS = 192
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            baud_i,
    input  logic [REQUESTERS-1:0]           req_valid_i,
    input  logic [REQUESTERS*WORD_BITS-1:0] req_data_i,
    input  logic [REQUESTERS-1:0]           req_last_i,
    output logic [REQUESTERS-1:0]           req_ready_o,
    output logic                            tx_start_o,
    output logic [WORD_BITS-1:0]            tx_data_o,
    input  logic                            tx_done_i,
    output logic [REQUESTERS-1:0]           grant_o,
    output logic                            busy_o,
    output logic                            timeout_o
);

    localparam int RR_W  = $clog2(REQUESTERS);
    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_TICKS);
    localparam logic [RR_W-1:0]  LAST_REQ = RR_W'(REQUESTERS - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

    typedef struct packed {
        logic                 last;
        logic [WORD_BITS-1:0] data;
    } beat_t;

    state_t                  state, state_nxt;
    beat_t [REQUESTERS-1:0]  beats;
    beat_t                   sel_beat;
    logic [RR_W-1:0]         rr, owner, owner_inc, winner, sel_idx;
    logic [RR_W:0]           probe;
    logic                    win_found, armed, last_q, xfer;
    logic                    timeout_hit, release_grant;
    logic [CNT_W-1:0]        cnt;

    for (genvar g = 0; g < REQUESTERS; g++) begin : g_beat
        assign beats[g] = '{last: req_last_i[g], data: req_data_i[g*WORD_BITS +: WORD_BITS]};
    end

    // Search rr, rr+1, ... modulo REQUESTERS. Walking the offsets from the far
    // end lets the nearest valid requester overwrite the others.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        probe     = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            probe = {1'b0, rr} + (RR_W+1)'(k);
            if (probe >= (RR_W+1)'(REQUESTERS))
                probe = probe - (RR_W+1)'(REQUESTERS);
            if (req_valid_i[probe[RR_W-1:0]]) begin
                winner    = probe[RR_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    // armed holds ready low from reset until the first edge with reset low.
    always_comb begin
        req_ready_o = '0;
        if (armed) begin
            if (state == IDLE && win_found) req_ready_o[winner] = 1'b1;
            if (state == HOLD)              req_ready_o[owner]  = 1'b1;
        end
    end

    assign xfer      = |(req_ready_o & req_valid_i);
    assign sel_idx   = (state == HOLD) ? owner : winner;
    assign sel_beat  = beats[sel_idx];
    assign owner_inc = (owner == LAST_REQ) ? '0 : owner + RR_W'(1);

    assign timeout_hit   = (state == HOLD) && !xfer && (cnt == CNT_MAX);
    assign release_grant = ((state == WAIT) && tx_done_i && last_q) || timeout_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (xfer) state_nxt = SEND;
            SEND: state_nxt = WAIT;
            WAIT: if (tx_done_i) state_nxt = last_q ? IDLE : HOLD;
            HOLD: begin
                if (xfer)             state_nxt = SEND;
                else if (timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            armed     <= 1'b0;
            rr        <= '0;
            owner     <= '0;
            grant_o   <= '0;
            tx_data_o <= '0;
            last_q    <= 1'b0;
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            armed     <= 1'b1;
            timeout_o <= timeout_hit;
            if (xfer) begin
                tx_data_o <= sel_beat.data;
                last_q    <= sel_beat.last;
                if (state == IDLE) begin
                    owner   <= winner;
                    grant_o <= {{(REQUESTERS-1){1'b0}}, 1'b1} << winner;
                end
            end
            if (release_grant) begin
                grant_o <= '0;
                rr      <= owner_inc;
            end
            // Cleared throughout WAIT so HOLD always starts from zero.
            if (state == WAIT)
                cnt <= '0;
            else if (state == HOLD && baud_i && cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign tx_start_o = (state == SEND);
    assign busy_o     = (state != IDLE);

endmodule
